// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl
//   Multicycle RV32I control FSM. One instruction in flight:
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. It drives the ALU op and the
//   datapath selects, and resolves conditional branches from the ALU flags.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   instr[31:0]         instruction register, valid from DECODE onward
//   mem_ready           memory completes the current request this cycle
//   BrEq/BrLt/BrLtU     ALU compare flags (equal, signed less, unsigned less)
//   alu_src[3:0]        ALU op: 1 ADD 2 SUB 3 AND 4 OR 5 XOR 6 SLL 7 SRL
//                       8 SRA 9 SLT 10 SLTU
//   a_sel[1:0]          ALU A: 0 rs1, 1 PC, 2 OLDPC, 3 zero
//   b_sel[1:0]          ALU B: 0 rs2, 1 imm, 2 const 4
//   pc_write, pc_src    PC load strobe; source 0 ALU result, 1 alu_out reg
//   ir_write            latch fetched word into IR and PC into OLDPC
//   mem_req, mem_we     memory request / store qualifier
//   reg_write, wb_sel   register write strobe; source 0 alu_out, 1 mem, 2 PC
//   trap, trap_cause    sticky fault; cause 1 illegal instr, 2 mem timeout
//   retire              one-cycle pulse per completed instruction
//   dbg_state[2:0]      current FSM state
//
// Memory handshake: mem_req is held high (with stable address/we) for as
// long as the FSM waits; the transfer completes in the first cycle where
// mem_req and mem_ready are both high. mem_ready without mem_req is ignored.

module rv32i_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        BrEq,
    input  logic        BrLt,
    input  logic        BrLtU,
    output logic [3:0]  alu_src,
    output logic [1:0]  a_sel,
    output logic [1:0]  b_sel,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic        retire,
    output logic [2:0]  dbg_state
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    cause_r, cause_next;
    logic [3:0]    alu_fn;
    logic          legal, taken, timed_out;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign f7b5   = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign timed_out = (MEM_TIMEOUT != 0) && (cnt == TMO);

    // R-type and I-ALU share the funct3 map; only R-type has SUB, while
    // funct7[5] selects SRA for both register and immediate shifts.
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_fn = (opcode == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        // Branch funct3 010/011 are unallocated.
        if (opcode == OP_BRANCH && funct3[2:1] == 2'b01) legal = 1'b0;
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = BrEq;
            3'b001:  taken = !BrEq;
            3'b100:  taken = BrLt;
            3'b101:  taken = !BrLt;
            3'b110:  taken = BrLtU;
            3'b111:  taken = !BrLtU;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            cnt     <= '0;
            cause_r <= 2'd0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                cnt <= cnt + CW'(1);
            if (state_next == S_TRAP && state != S_TRAP)
                cause_r <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        cause_next = 2'd0;
        alu_src    = ALU_ADD;
        a_sel      = 2'd0;
        b_sel      = 2'd0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'd0;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                a_sel   = 2'd1;
                b_sel   = 2'd2;
                // mem_ready beats a timeout landing on the same cycle.
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = 2'd2;
                end
            end
            S_DECODE: begin
                // Precompute OLDPC+imm so branch/JAL targets sit in alu_out.
                a_sel = 2'd2;
                b_sel = 2'd1;
                if (legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_TRAP;
                    cause_next = 2'd1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_src    = alu_fn;
                        state_next = S_WB;
                    end
                    OP_I: begin
                        alu_src    = alu_fn;
                        b_sel      = 2'd1;
                        state_next = S_WB;
                    end
                    OP_LUI: begin
                        a_sel      = 2'd3;
                        b_sel      = 2'd1;
                        state_next = S_WB;
                    end
                    OP_AUIPC: begin
                        a_sel      = 2'd2;
                        b_sel      = 2'd1;
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        b_sel      = 2'd1;
                        state_next = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src    = ALU_SUB;
                        pc_write   = taken;
                        pc_src     = taken;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JAL: begin
                        // PC still holds the return address this cycle.
                        pc_write   = 1'b1;
                        pc_src     = 1'b1;
                        reg_write  = 1'b1;
                        wb_sel     = 2'd2;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JALR: begin
                        b_sel      = 2'd1;
                        pc_write   = 1'b1;
                        reg_write  = 1'b1;
                        wb_sel     = 2'd2;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        state_next = S_TRAP;
                        cause_next = 2'd1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
                b_sel   = 2'd1;
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timed_out) begin
                    state_next = S_TRAP;
                    cause_next = 2'd2;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Nothing may write while reset is asserted, whatever the state.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_r;
    assign dbg_state  = state;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Testbench for rv32i_mc_ctrl: per-cycle vector table plus timeout and
// reset sequences. DUT built with MEM_TIMEOUT=4.

module tb_rv32i_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        mem_ready = 1'b0;
    logic        BrEq = 1'b0, BrLt = 1'b0, BrLtU = 1'b0;
    logic [3:0]  alu_src;
    logic [1:0]  a_sel, b_sel, wb_sel, trap_cause;
    logic        pc_write, pc_src, ir_write, mem_req, mem_we, reg_write;
    logic        trap, retire;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32i_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .BrEq(BrEq), .BrLt(BrLt), .BrLtU(BrLtU),
        .alu_src(alu_src), .a_sel(a_sel), .b_sel(b_sel),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
        .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause),
        .retire(retire), .dbg_state(dbg_state)
    );

    logic [22:0] act;
    assign act = {dbg_state, alu_src, a_sel, b_sel, pc_write, pc_src, ir_write,
                  mem_req, mem_we, reg_write, wb_sel, trap, trap_cause, retire};

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] ins;
        logic        mr, beq, blt, bltu;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4020D193;
    localparam logic [31:0] I_SLTU  = 32'h0020B1B3;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_BLTU  = 32'h0020E463;
    localparam logic [31:0] I_BGE   = 32'h0020D463;
    localparam logic [31:0] I_BBAD  = 32'h0020A463;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_LUI   = 32'h123451B7;
    localparam logic [31:0] I_AUIPC = 32'h00001197;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    // Expected output word: state, alu, a, b, pc_write, pc_src, ir_write,
    // mem_req, mem_we, reg_write, wb_sel, trap, trap_cause, retire.
    function automatic logic [22:0] o(int st, int alu, int a, int b, int pw,
                                      int ps, int iw, int mq, int mw, int rw,
                                      int wb, int tr, int tc, int ret);
        return {3'(st), 4'(alu), 2'(a), 2'(b), 1'(pw), 1'(ps), 1'(iw),
                1'(mq), 1'(mw), 1'(rw), 2'(wb), 1'(tr), 2'(tc), 1'(ret)};
    endfunction

    function automatic void add(string n, logic r, logic [31:0] ins, logic mr,
                                logic be, logic bl, logic blu, logic [22:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.ins = ins; v.mr = mr;
        v.beq = be; v.blt = bl; v.bltu = blu; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic apply(input logic r, input logic [31:0] ins, input logic mr,
                         input logic be, input logic bl, input logic blu);
        @(negedge clk);
        rst_n = r; instr = ins; mem_ready = mr;
        BrEq = be; BrLt = bl; BrLtU = blu;
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", n, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] f_go, dec, wb_alu, wb_ld, mem_ld, trap1;
        int waits;
        bit seen;

        f_go   = o(0, 1, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        dec    = o(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_alu = o(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        wb_ld  = o(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        mem_ld = o(3, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        trap1  = o(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        add("reset", 0, I_ADD, 1, 0, 0, 0, o(0,1,1,2,0,0,0,0,0,0,0,0,0,0));
        add("add_f", 1, I_ADD, 1, 0, 0, 0, f_go);
        add("add_d", 1, I_ADD, 0, 0, 0, 0, dec);
        add("add_e", 1, I_ADD, 0, 0, 0, 0, o(2,1,0,0,0,0,0,0,0,0,0,0,0,0));
        add("add_w", 1, I_ADD, 0, 0, 0, 0, wb_alu);
        add("sub_f", 1, I_SUB, 1, 0, 0, 0, f_go);
        add("sub_d", 1, I_SUB, 0, 0, 0, 0, dec);
        add("sub_e", 1, I_SUB, 0, 0, 0, 0, o(2,2,0,0,0,0,0,0,0,0,0,0,0,0));
        add("sub_w", 1, I_SUB, 0, 0, 0, 0, wb_alu);
        add("srai_f", 1, I_SRAI, 1, 0, 0, 0, f_go);
        add("srai_d", 1, I_SRAI, 0, 0, 0, 0, dec);
        add("srai_e", 1, I_SRAI, 0, 0, 0, 0, o(2,8,0,1,0,0,0,0,0,0,0,0,0,0));
        add("srai_w", 1, I_SRAI, 0, 0, 0, 0, wb_alu);
        add("sltu_f", 1, I_SLTU, 1, 0, 0, 0, f_go);
        add("sltu_d", 1, I_SLTU, 0, 0, 0, 0, dec);
        add("sltu_e", 1, I_SLTU, 0, 0, 0, 0, o(2,10,0,0,0,0,0,0,0,0,0,0,0,0));
        add("sltu_w", 1, I_SLTU, 0, 0, 0, 0, wb_alu);
        add("beq_f", 1, I_BEQ, 1, 0, 0, 0, f_go);
        add("beq_d", 1, I_BEQ, 0, 0, 0, 0, dec);
        add("beq_e", 1, I_BEQ, 0, 1, 0, 0, o(2,2,0,0,1,1,0,0,0,0,0,0,0,1));
        add("bne_f", 1, I_BNE, 1, 0, 0, 0, f_go);
        add("bne_d", 1, I_BNE, 0, 0, 0, 0, dec);
        add("bne_e", 1, I_BNE, 0, 1, 0, 0, o(2,2,0,0,0,0,0,0,0,0,0,0,0,1));
        add("bltu_f", 1, I_BLTU, 1, 0, 0, 0, f_go);
        add("bltu_d", 1, I_BLTU, 0, 0, 0, 0, dec);
        add("bltu_e", 1, I_BLTU, 0, 0, 0, 1, o(2,2,0,0,1,1,0,0,0,0,0,0,0,1));
        add("bge_f", 1, I_BGE, 1, 0, 0, 0, f_go);
        add("bge_d", 1, I_BGE, 0, 0, 0, 0, dec);
        add("bge_e", 1, I_BGE, 0, 0, 1, 0, o(2,2,0,0,0,0,0,0,0,0,0,0,0,1));
        add("lw_f", 1, I_LW, 1, 0, 0, 0, f_go);
        add("lw_d", 1, I_LW, 0, 0, 0, 0, dec);
        add("lw_e", 1, I_LW, 0, 0, 0, 0, o(2,1,0,1,0,0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 3; k++) add("lw_mwait", 1, I_LW, 0, 0, 0, 0, mem_ld);
        add("lw_mdone", 1, I_LW, 1, 0, 0, 0, mem_ld);
        add("lw_w", 1, I_LW, 0, 0, 0, 0, wb_ld);
        add("sw_f", 1, I_SW, 1, 0, 0, 0, f_go);
        add("sw_d", 1, I_SW, 0, 0, 0, 0, dec);
        add("sw_e", 1, I_SW, 0, 0, 0, 0, o(2,1,0,1,0,0,0,0,0,0,0,0,0,0));
        add("sw_m", 1, I_SW, 1, 0, 0, 0, o(3,1,0,1,0,0,0,1,1,0,0,0,0,1));
        add("jal_f", 1, I_JAL, 1, 0, 0, 0, f_go);
        add("jal_d", 1, I_JAL, 0, 0, 0, 0, dec);
        add("jal_e", 1, I_JAL, 0, 0, 0, 0, o(2,1,0,0,1,1,0,0,0,1,2,0,0,1));
        add("jalr_f", 1, I_JALR, 1, 0, 0, 0, f_go);
        add("jalr_d", 1, I_JALR, 0, 0, 0, 0, dec);
        add("jalr_e", 1, I_JALR, 0, 0, 0, 0, o(2,1,0,1,1,0,0,0,0,1,2,0,0,1));
        add("lui_f", 1, I_LUI, 1, 0, 0, 0, f_go);
        add("lui_d", 1, I_LUI, 0, 0, 0, 0, dec);
        add("lui_e", 1, I_LUI, 0, 0, 0, 0, o(2,1,3,1,0,0,0,0,0,0,0,0,0,0));
        add("lui_w", 1, I_LUI, 0, 0, 0, 0, wb_alu);
        add("auipc_f", 1, I_AUIPC, 1, 0, 0, 0, f_go);
        add("auipc_d", 1, I_AUIPC, 0, 0, 0, 0, dec);
        add("auipc_e", 1, I_AUIPC, 0, 0, 0, 0, o(2,1,2,1,0,0,0,0,0,0,0,0,0,0));
        add("auipc_w", 1, I_AUIPC, 0, 0, 0, 0, wb_alu);
        // MEM: ready arriving exactly at the timeout count still completes.
        add("lwt_f", 1, I_LW, 1, 0, 0, 0, f_go);
        add("lwt_d", 1, I_LW, 0, 0, 0, 0, dec);
        add("lwt_e", 1, I_LW, 0, 0, 0, 0, o(2,1,0,1,0,0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < 4; k++) add("lwt_mwait", 1, I_LW, 0, 0, 0, 0, mem_ld);
        add("lwt_mlast", 1, I_LW, 1, 0, 0, 0, mem_ld);
        add("lwt_w", 1, I_LW, 0, 0, 0, 0, wb_ld);
        // Reset in MEM: strobes drop at once, FETCH on the next cycle.
        add("rm_f", 1, I_LW, 1, 0, 0, 0, f_go);
        add("rm_d", 1, I_LW, 0, 0, 0, 0, dec);
        add("rm_e", 1, I_LW, 0, 0, 0, 0, o(2,1,0,1,0,0,0,0,0,0,0,0,0,0));
        add("rm_rst", 0, I_LW, 1, 0, 0, 0, o(3,1,0,1,0,0,0,0,0,0,0,0,0,0));
        add("rm_fetch", 1, I_LW, 0, 0, 0, 0, o(0,1,1,2,0,0,0,1,0,0,0,0,0,0));
        // Illegal opcode and reserved branch funct3.
        add("ill_f", 1, I_ILL, 1, 0, 0, 0, f_go);
        add("ill_d", 1, I_ILL, 0, 0, 0, 0, dec);
        add("ill_t1", 1, I_ILL, 1, 1, 1, 1, trap1);
        add("ill_t2", 1, I_ADD, 1, 0, 0, 0, trap1);
        add("ill_rst", 0, I_ADD, 1, 0, 0, 0, trap1 & ~23'h000001);
        add("ill_after", 1, I_BBAD, 1, 0, 0, 0, f_go);
        add("bbad_d", 1, I_BBAD, 0, 0, 0, 0, dec);
        add("bbad_t", 1, I_BBAD, 1, 0, 0, 0, trap1);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ins, vecs[i].mr,
                  vecs[i].beq, vecs[i].blt, vecs[i].bltu);
            check(vecs[i].name, 32'(act), 32'(vecs[i].exp));
        end

        // FETCH with mem_ready stuck low: five waiting cycles, then TRAP.
        apply(0, I_ADD, 0, 0, 0, 0);
        waits = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            apply(1, I_ADD, 0, 0, 0, 0);
            if (trap) seen = 1;
            else      waits++;
        end
        check("fetch_tmo_seen", 32'(seen), 1);
        check("fetch_tmo_cycles", waits, 5);
        check("fetch_tmo_cause", 32'(trap_cause), 2);
        check("fetch_tmo_req", 32'(mem_req), 0);

        // MEM (store) with mem_ready stuck low.
        apply(0, I_SW, 0, 0, 0, 0);
        apply(1, I_SW, 1, 0, 0, 0);
        apply(1, I_SW, 0, 0, 0, 0);
        apply(1, I_SW, 0, 0, 0, 0);
        waits = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            apply(1, I_SW, 0, 0, 0, 0);
            if (trap) seen = 1;
            else if (dbg_state == 3'd3) waits++;
        end
        check("mem_tmo_seen", 32'(seen), 1);
        check("mem_tmo_cycles", waits, 5);
        check("mem_tmo_cause", 32'(trap_cause), 2);
        check("mem_tmo_we", 32'(mem_we), 0);

        apply(0, I_SW, 0, 0, 0, 0);
        apply(1, I_SW, 0, 0, 0, 0);
        check("trap_cleared", 32'({trap, trap_cause, dbg_state}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
- Multicycle RV32I control FSM; drives the ALU opcode (alu_src) and datapath selects.
- Consumes the ALU branch flags BrEq/BrLt/BrLtU to resolve conditional branches.
- Sits between the instruction register and the shared datapath (ALU, register file, PC, memory port).
- One instruction in flight: FETCH → DECODE → EXEC → [MEM] → [WB].

Parameters:
- MEM_TIMEOUT, default 255: max cycles waiting for mem_ready in FETCH/MEM before trapping. 0 disables the timeout.

Ports:
- clk  in  1: clock.
- rst_n  in  1: synchronous active-low reset.
- instr  in  32: instruction register contents, valid from DECODE onward.
- mem_ready  in  1: memory completes current request this cycle.
- BrEq  in  1: ALU flag, result==0.
- BrLt  in  1: ALU flag, signed a<b.
- BrLtU  in  1: ALU flag, unsigned a<b.
- alu_src  out  4: ALU op; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU.
- a_sel  out  2: ALU A source; 0 rs1, 1 PC, 2 OLDPC, 3 zero.
- b_sel  out  2: ALU B source; 0 rs2, 1 imm, 2 const 4.
- pc_write  out  1: load PC at clock edge.
- pc_src  out  1: PC source; 0 ALU result (bit0 cleared by datapath), 1 alu_out register.
- ir_write  out  1: latch fetched word into IR and PC into OLDPC.
- mem_req  out  1: memory request.
- mem_we  out  1: store when mem_req=1.
- reg_write  out  1: register file write strobe.
- wb_sel  out  2: write-back source; 0 alu_out, 1 mem data, 2 PC.
- trap  out  1: sticky fault indicator.
- trap_cause  out  2: 0 none, 1 illegal instruction, 2 memory timeout.
- retire  out  1: one-cycle pulse per completed instruction.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (rst_n=0 at edge): state→FETCH, wait counter→0, trap→0, trap_cause→0.
- All strobes (pc_write, ir_write, mem_req, mem_we, reg_write, retire) are 0 while rst_n=0. Reset mid-instruction abandons the instruction with no writes.
- Selects default to alu_src=ADD, a_sel=0, b_sel=0, wb_sel=0, pc_src=0 when unused.
- FETCH: mem_req=1, a_sel=1, b_sel=2, ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0 (PC←PC+4), →DECODE.
  - Otherwise stay and increment the counter.
- DECODE (1 cycle): a_sel=2, b_sel=1, ADD (branch/JAL target into alu_out).
  - Legal opcode →EXEC; illegal opcode or branch funct3 010/011 →TRAP, cause 1.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- Funct decode for R and I-ALU, by funct3:
  - 000: ADD, or SUB when R-type and funct7[5]=1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110: OR. 111: AND.
  - Other funct7 bits are ignored.
- EXEC by opcode:
  - R-type: a=rs1, b=rs2 →WB.
  - I-ALU: a=rs1, b=imm →WB.
  - LUI: a=zero, b=imm, ADD →WB.
  - AUIPC: a=OLDPC, b=imm, ADD →WB.
  - LOAD/STORE: a=rs1, b=imm, ADD →MEM.
  - BRANCH: a=rs1, b=rs2, SUB. Taken condition by funct3: 000 BrEq, 001 !BrEq, 100 BrLt, 101 !BrLt, 110 BrLtU, 111 !BrLtU.
    - Taken: pc_write=1, pc_src=1.
    - Either way: retire=1, →FETCH.
  - JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=2 (pre-update PC = link) in the same cycle; retire=1, →FETCH.
  - JALR: a=rs1, b=imm, ADD, pc_write=1, pc_src=0, reg_write=1, wb_sel=2; retire=1, →FETCH.
- MEM: mem_req=1, mem_we=store, a=rs1, b=imm, ADD held stable.
  - On mem_ready: load →WB; store sets retire=1 and →FETCH.
- WB: reg_write=1, wb_sel=1 for load else 0; retire=1, →FETCH.
- Timeout counter:
  - Clears on every state entry.
  - When counter==MEM_TIMEOUT while waiting in FETCH/MEM (MEM_TIMEOUT≠0): →TRAP, cause 2.
  - mem_ready in the same cycle as the timeout wins (no trap).
- TRAP: all strobes 0, trap=1; held until reset.
- rd=x0 writes still assert reg_write; the register file ignores x0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 in FETCH → DECODE, EXEC alu_src=1 a_sel=0 b_sel=0, WB reg_write=1 wb_sel=0; retire on cycle 4.
- SUB x3,x1,x2 (0x402081B3) → alu_src=2. SRAI (0x4020D193) → alu_src=8, b_sel=1. SLTU (0x0020B1B3) → alu_src=10.
- BEQ (0x00208463) with BrEq=1 in EXEC → alu_src=2, pc_write=1, pc_src=1. BNE with BrEq=1 → pc_write=0; BLTU with BrLtU=1 → taken.
- LW (0x0000A183) with mem_ready low 3 cycles in MEM → mem_req held 4 cycles, then WB wb_sel=1. SW (0x0020A023) → mem_we=1, no WB, retire at MEM exit.
- JAL (0x008000EF) → EXEC pc_write=1, pc_src=1, reg_write=1, wb_sel=2 in the same cycle.
- Opcode 0x0000007F → TRAP, trap_cause=1, no strobes thereafter. mem_ready stuck 0 with MEM_TIMEOUT=4 → TRAP, cause 2. rst_n=0 mid-MEM → FETCH next cycle, trap cleared.
